// File: rtl/sdram_bist.sv
// Built-in self-test engine for the SDRAM path: writes a pattern over an address
// window through the controller request interface, reads it back and reports mismatches.
module sdram_bist #(
    parameter int ADDR_W  = 24,
    parameter int DATA_W  = 16,
    parameter int ERR_W   = 24,
    parameter int TIMEOUT = 64,
    parameter int TO_W    = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] addr_lo,
    input  logic [ADDR_W-1:0] addr_hi,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [DATA_W-1:0] first_err_data,
    output logic              first_err_valid,
    output logic              rw,
    output logic              rw_en,
    output logic [ADDR_W-1:0] f_addr,
    output logic [DATA_W-1:0] f2s_data,
    input  logic [DATA_W-1:0] s2f_data,
    input  logic              s2f_data_valid,
    input  logic              ready
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WRITE   = 3'd1;
    localparam logic [2:0] S_RD_REQ  = 3'd2;
    localparam logic [2:0] S_RD_WAIT = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] DW_AS_A  = ADDR_W'(DATA_W);

    // Address is resized to DATA_W first, so narrow addresses are zero-extended.
    function automatic logic [DATA_W-1:0] pattern(input logic [1:0] m, input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] p;
        p = '0;
        case (m)
            2'd0:    p = ~DATA_W'(a);
            2'd1:    p = DATA_W'(a);
            2'd2:    p = DATA_W'(1) << (a % DW_AS_A);
            default: for (int i = 0; i < DATA_W; i++) p[i] = (i % 2 == 0) ^ a[0];
        endcase
        return p;
    endfunction

    logic [2:0]        state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [ADDR_W-1:0] lo_q, lo_d;
    logic [ADDR_W-1:0] hi_q, hi_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
    logic [ADDR_W-1:0] fe_addr_q, fe_addr_d;
    logic [DATA_W-1:0] fe_data_q, fe_data_d;
    logic              fe_valid_q, fe_valid_d;
    logic              pass_q, pass_d;
    logic              timeout_q, timeout_d;

    logic [DATA_W-1:0] pat;
    logic              issue;
    logic              mismatch;

    assign pat      = pattern(mode_q, addr_q);
    assign issue    = ready && (state_q == S_WRITE || state_q == S_RD_REQ);
    assign mismatch = (state_q == S_RD_WAIT) && s2f_data_valid && (s2f_data != pat);

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        lo_d       = lo_q;
        hi_d       = hi_q;
        addr_d     = addr_q;
        to_cnt_d   = to_cnt_q;
        err_cnt_d  = err_cnt_q;
        fe_addr_d  = fe_addr_q;
        fe_data_d  = fe_data_q;
        fe_valid_d = fe_valid_q;
        pass_d     = pass_q;
        timeout_d  = timeout_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d     = mode;
                    lo_d       = addr_lo;
                    hi_d       = addr_hi;
                    err_cnt_d  = '0;
                    fe_addr_d  = '0;
                    fe_data_d  = '0;
                    fe_valid_d = 1'b0;
                    timeout_d  = 1'b0;
                    pass_d     = 1'b0;
                    if (addr_lo > addr_hi) begin
                        state_d = S_DONE;
                    end else begin
                        addr_d  = addr_lo;
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                if (ready) begin
                    if (addr_q == hi_q) begin
                        addr_d  = lo_q;
                        state_d = S_RD_REQ;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            S_RD_REQ: begin
                if (ready) begin
                    to_cnt_d = '0;
                    state_d  = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                // Data arriving on the final count still wins over the timeout.
                if (s2f_data_valid) begin
                    if (mismatch) begin
                        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
                        if (!fe_valid_q) begin
                            fe_addr_d  = addr_q;
                            fe_data_d  = s2f_data;
                            fe_valid_d = 1'b1;
                        end
                    end
                    if (addr_q == hi_q) begin
                        pass_d  = (err_cnt_q == '0) && !mismatch;
                        state_d = S_DONE;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = S_RD_REQ;
                    end
                end else if (to_cnt_q == TO_LAST) begin
                    timeout_d = 1'b1;
                    pass_d    = 1'b0;
                    state_d   = S_DONE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            mode_q     <= '0;
            lo_q       <= '0;
            hi_q       <= '0;
            addr_q     <= '0;
            to_cnt_q   <= '0;
            err_cnt_q  <= '0;
            fe_addr_q  <= '0;
            fe_data_q  <= '0;
            fe_valid_q <= 1'b0;
            pass_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            lo_q       <= lo_d;
            hi_q       <= hi_d;
            addr_q     <= addr_d;
            to_cnt_q   <= to_cnt_d;
            err_cnt_q  <= err_cnt_d;
            fe_addr_q  <= fe_addr_d;
            fe_data_q  <= fe_data_d;
            fe_valid_q <= fe_valid_d;
            pass_q     <= pass_d;
            timeout_q  <= timeout_d;
        end
    end

    // Request outputs are decoded from state so an async reset silences them at once.
    assign busy            = (state_q == S_WRITE) || (state_q == S_RD_REQ) || (state_q == S_RD_WAIT);
    assign done            = (state_q == S_DONE);
    assign pass            = pass_q;
    assign timeout         = timeout_q;
    assign err_cnt         = err_cnt_q;
    assign first_err_addr  = fe_addr_q;
    assign first_err_data  = fe_data_q;
    assign first_err_valid = fe_valid_q;
    assign rw_en           = issue;
    assign rw              = issue && (state_q == S_RD_REQ);
    assign f_addr          = issue ? addr_q : '0;
    assign f2s_data        = (issue && state_q == S_WRITE) ? pat : '0;

endmodule

// File: tb/tb_sdram_bist.sv
// Randomised scoreboard bench for sdram_bist with a behavioural SDRAM controller model.
module tb_sdram_bist;

    localparam int AW  = 24;
    localparam int DW  = 16;
    localparam int EW  = 24;
    localparam int TMO = 64;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [1:0]    mode;
    logic [AW-1:0] addr_lo;
    logic [AW-1:0] addr_hi;
    logic          busy, done, pass, timeout;
    logic [EW-1:0] err_cnt;
    logic [AW-1:0] first_err_addr;
    logic [DW-1:0] first_err_data;
    logic          first_err_valid;
    logic          rw, rw_en;
    logic [AW-1:0] f_addr;
    logic [DW-1:0] f2s_data;
    logic [DW-1:0] s2f_data;
    logic          s2f_data_valid;
    logic          ready;

    sdram_bist #(.ADDR_W(AW), .DATA_W(DW), .ERR_W(EW), .TIMEOUT(TMO), .TO_W(7)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .addr_lo(addr_lo), .addr_hi(addr_hi),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .err_cnt(err_cnt), .first_err_addr(first_err_addr),
        .first_err_data(first_err_data), .first_err_valid(first_err_valid),
        .rw(rw), .rw_en(rw_en), .f_addr(f_addr), .f2s_data(f2s_data),
        .s2f_data(s2f_data), .s2f_data_valid(s2f_data_valid), .ready(ready)
    );

    typedef struct { bit rd; int addr; int data; } req_t;
    typedef struct { bit pass; bit tmo; bit bad; bit fev; int errs; int fea; int fed; } res_t;

    req_t exp_req[$];
    res_t exp_res[$];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int start_cyc = 0;
    int last_req_cyc = 0;
    int last_req_addr = -1;
    bit last_req_rd = 0;

    // controller model configuration and state
    int ready_mode = 0;
    int drop_idx = -1;
    int lat_min = 3;
    int lat_max = 3;
    int rd_count = 0;
    int mem[int];
    int corrupt[int];
    bit pend = 0;
    int due = 0;
    int due_data = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int pat(input int m, input int a);
        case (m)
            0:       return (~a) & 16'hFFFF;
            1:       return a & 16'hFFFF;
            2:       return 1 << (a % DW);
            default: return (a % 2 == 1) ? 16'hAAAA : 16'h5555;
        endcase
    endfunction

    // Expected request stream and final result, derived from the test rules directly.
    task automatic build_exp(input int m, input int lo, input int hi, input int drop, output res_t r);
        int d;
        r = '{pass: 1'b0, tmo: 1'b0, bad: 1'b0, fev: 1'b0, errs: 0, fea: 0, fed: 0};
        if (lo > hi) begin
            r.bad = 1'b1;
        end else begin
            for (int a = lo; a <= hi; a++) exp_req.push_back('{1'b0, a, pat(m, a)});
            for (int k = 0; k <= hi - lo; k++) begin
                exp_req.push_back('{1'b1, lo + k, 0});
                if (k == drop) begin
                    r.tmo = 1'b1;
                    break;
                end
                d = pat(m, lo + k) ^ (corrupt.exists(lo + k) ? corrupt[lo + k] : 0);
                if (d != pat(m, lo + k)) begin
                    r.errs++;
                    if (!r.fev) begin
                        r.fev = 1'b1;
                        r.fea = lo + k;
                        r.fed = d;
                    end
                end
            end
            r.pass = !r.tmo && (r.errs == 0);
        end
        exp_res.push_back(r);
    endtask

    // Controller model: accepts requests, keeps memory, returns reads after a latency.
    initial begin
        int k;
        ready = 1'b1;
        s2f_data_valid = 1'b0;
        s2f_data = '0;
        forever begin
            @(negedge clk);
            if (rst_n && rw_en) begin
                k = int'(f_addr);
                if (!rw) begin
                    mem[k] = int'(f2s_data);
                end else begin
                    if (rd_count != drop_idx) begin
                        pend = 1'b1;
                        due = cyc + int'($urandom_range(lat_max, lat_min));
                        due_data = (mem.exists(k) ? mem[k] : 0) ^ (corrupt.exists(k) ? corrupt[k] : 0);
                    end
                    rd_count++;
                end
            end
            @(posedge clk);
            #1;
            if (!rst_n) pend = 1'b0;
            case (ready_mode)
                0:       ready = 1'b1;
                1:       ready = ~ready;
                default: ready = ($urandom_range(3, 0) != 0);
            endcase
            if (pend && cyc == due) begin
                s2f_data_valid = 1'b1;
                s2f_data = DW'(due_data);
                pend = 1'b0;
            end else begin
                s2f_data_valid = 1'b0;
                s2f_data = DW'($urandom);
            end
        end
    end

    // Monitor: pops expectations whenever the DUT issues a request or signals done.
    initial begin
        req_t q;
        res_t r;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (rw_en) begin
                    chk("req_ready", int'(ready), 1);
                    chk("req_busy", int'(busy), 1);
                    if (exp_req.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_req: got rw=%0d addr=%0h, expected no request", rw, f_addr);
                    end else begin
                        q = exp_req.pop_front();
                        chk("req_rw", int'(rw), int'(q.rd));
                        chk("req_addr", int'(f_addr), q.addr);
                        if (!q.rd) chk("req_wdata", int'(f2s_data), q.data);
                    end
                    last_req_cyc = cyc;
                    last_req_addr = int'(f_addr);
                    last_req_rd = rw;
                end else begin
                    chk("idle_wdata", int'(f2s_data), 0);
                end
                if (done) begin
                    if (exp_res.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_done: got done=1, expected no done");
                    end else begin
                        r = exp_res.pop_front();
                        chk("done_busy", int'(busy), 0);
                        chk("pass", int'(pass), int'(r.pass));
                        chk("timeout", int'(timeout), int'(r.tmo));
                        chk("err_cnt", int'(err_cnt), r.errs);
                        chk("first_err_valid", int'(first_err_valid), int'(r.fev));
                        if (r.fev) begin
                            chk("first_err_addr", int'(first_err_addr), r.fea);
                            chk("first_err_data", int'(first_err_data), r.fed);
                        end
                        if (r.tmo) chk("timeout_latency", cyc - last_req_cyc, TMO + 1);
                        if (r.bad) chk("bad_range_latency_ok", int'((cyc - start_cyc) >= 1 && (cyc - start_cyc) <= 2), 1);
                    end
                end
            end
        end
    end

    task automatic pulse_start(input int m, input int lo, input int hi);
        @(posedge clk);
        #1;
        start = 1'b1;
        mode = 2'(m);
        addr_lo = AW'(lo);
        addr_hi = AW'(hi);
        start_cyc = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (exp_res.size() != 0 && n < 5000) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("done_seen_in_budget", exp_res.size(), 0);
        exp_res.delete();
    endtask

    task automatic run_bist(input int m, input int lo, input int hi, input int rmode,
                            input int drop, input bit poke_busy, input bit poke_done);
        res_t r;
        rd_count = 0;
        mem.delete();
        ready_mode = rmode;
        drop_idx = drop;
        build_exp(m, lo, hi, drop, r);
        pulse_start(m, lo, hi);
        if (poke_busy) begin
            repeat (4) @(posedge clk);
            #1;
            chk("busy_mid_run", int'(busy), 1);
            start = 1'b1;
            mode = 2'(3 - m);
            addr_lo = '0;
            addr_hi = AW'(3);
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        wait_done();
        if (poke_done) begin
            // still inside the DONE cycle: this start must be dropped
            start = 1'b1;
            addr_lo = '0;
            addr_hi = AW'(2);
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        chk("reqs_drained", exp_req.size(), 0);
        exp_req.delete();
        repeat (3) @(posedge clk);
        #1;
        chk("hold_busy", int'(busy), 0);
        chk("hold_pass", int'(pass), int'(r.pass));
        chk("hold_err_cnt", int'(err_cnt), r.errs);
        chk("hold_timeout", int'(timeout), int'(r.tmo));
        corrupt.delete();
        ready_mode = 0;
        drop_idx = -1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_pass"}, int'(pass), 0);
        chk({tag, "_timeout"}, int'(timeout), 0);
        chk({tag, "_err_cnt"}, int'(err_cnt), 0);
        chk({tag, "_fe_addr"}, int'(first_err_addr), 0);
        chk({tag, "_fe_data"}, int'(first_err_data), 0);
        chk({tag, "_fe_valid"}, int'(first_err_valid), 0);
        chk({tag, "_rw"}, int'(rw), 0);
        chk({tag, "_rw_en"}, int'(rw_en), 0);
        chk({tag, "_f_addr"}, int'(f_addr), 0);
        chk({tag, "_f2s_data"}, int'(f2s_data), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int m, lo, hi, len, drop, rmode;
        rst_n = 1'b0;
        start = 1'b0;
        mode = '0;
        addr_lo = '0;
        addr_hi = '0;
        #13;
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // clean mode-0 run
        run_bist(0, 'h10, 'h1F, 0, -1, 1'b0, 1'b0);
        // corrupted addresses, first error at 0x14
        corrupt[32'h14] = 1;
        corrupt[32'h19] = 'h0100;
        run_bist(0, 'h10, 'h1F, 0, -1, 1'b0, 1'b0);
        // walking one with ready toggling
        run_bist(2, 'h0, 'h11, 1, -1, 1'b0, 1'b0);
        // third read never answered
        run_bist(3, 'h40, 'h47, 0, 2, 1'b0, 1'b0);
        // inverted range, plus a start inside the DONE cycle
        run_bist(1, 'h20, 'h10, 0, -1, 1'b0, 1'b1);

        // reset during the write phase at 0x15
        rd_count = 0;
        mem.delete();
        last_req_addr = -1;
        begin
            res_t r;
            int n;
            build_exp(0, 'h10, 'h1F, -1, r);
            pulse_start(0, 'h10, 'h1F);
            n = 0;
            while (!(last_req_addr == 'h15 && !last_req_rd) && n < 200) begin
                @(negedge clk);
                #1;
                n++;
            end
            chk("reached_0x15", last_req_addr, 'h15);
            #1;
            rst_n = 1'b0;
            #1;
            check_all_zero("async_rst");
            exp_req.delete();
            exp_res.delete();
            repeat (3) begin
                @(negedge clk);
                chk("rst_no_rw_en", int'(rw_en), 0);
            end
            @(posedge clk);
            #1;
            rst_n = 1'b1;
            repeat (4) @(posedge clk);
        end
        // clean run after reset, with a start pulsed while busy
        run_bist(0, 'h10, 'h1F, 0, -1, 1'b1, 1'b0);

        // randomised runs
        lat_min = 1;
        lat_max = 10;
        for (int it = 0; it < 14; it++) begin
            m = int'($urandom_range(3, 0));
            len = int'($urandom_range(20, 1));
            lo = int'($urandom & 32'hFFFFFF);
            if (it == 0) lo = 'hFFFFF8;
            hi = lo + len - 1;
            if (hi > 'hFFFFFF) hi = 'hFFFFFF;
            if ($urandom_range(7, 0) == 0) begin
                int t;
                t = lo;
                lo = hi + 1;
                hi = t;
                if (lo > 'hFFFFFF) begin
                    lo = 'hFFFFFF;
                    hi = 'hFFFFF0;
                end
            end
            for (int a = lo; a <= hi; a++)
                if ($urandom_range(3, 0) == 0) corrupt[a] = int'($urandom_range(16'hFFFF, 1));
            drop = ($urandom_range(3, 0) == 0) ? int'($urandom_range(len - 1, 0)) : -1;
            rmode = int'($urandom_range(2, 0));
            run_bist(m, lo, hi, rmode, drop, 1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
